fb_rect_writer: RTL

//  Write-side counterpart of the VGA pixel-address path. Fills an axis-aligned rectangle of the
//  320x240 frame buffer with one colour, one pixel per clock, in raster order. Drives the

---
 rtl/fb_rect_writer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: fills a clipped axis-aligned rectangle of the frame buffer
// with one colour. It writes one pixel per clock in raster order on the BRAM
// write port and takes commands over a valid/ready handshake.
module fb_rect_writer #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [9:0]        FB_W10 = 10'(FB_W);
  localparam logic [9:0]        FB_H10 = 10'(FB_H);
  localparam logic [ADDR_W-1:0] FB_WA  = ADDR_W'(FB_W);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [8:0]          x_q, x_d, w_q, w_d, col_q, col_d;
  logic [7:0]          y_q, y_d, h_q, h_d, row_q, row_d;
  logic [9:0]          x_end_q, x_end_d, y_end_q, y_end_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d, done_q, done_d;
  logic                cmd_ready_q, cmd_ready_d, busy_q, busy_d;

  // Clip arithmetic is 10 bits wide, so x+w and y+h cannot overflow.
  logic [9:0]          x_sum, y_sum, x_lim, y_lim;
  logic                empty;
  logic [ADDR_W-1:0]   y_base;

  assign x_sum  = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum  = {2'b0, y_q} + {2'b0, h_q};
  assign x_lim  = (x_sum > FB_W10) ? FB_W10 : x_sum;
  assign y_lim  = (y_sum > FB_H10) ? FB_H10 : y_sum;
  assign empty  = (w_q == '0) || (h_q == '0) ||
                  ({1'b0, x_q} >= FB_W10) || ({2'b0, y_q} >= FB_H10);
  // Constant multiply; synthesis reduces it to a shift-add.
  assign y_base = ADDR_W'(y_q) * FB_WA;

  // Next-state and registered-output logic for the fill sequencer.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    row_d      = row_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = wr_en_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          x_d       = cmd_x;
          y_d       = cmd_y;
          w_d       = cmd_w;
          h_d       = cmd_h;
          wr_data_d = cmd_color;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        x_end_d = x_lim - 10'd1;
        y_end_d = y_lim - 10'd1;
        if (empty) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          col_d      = x_q;
          row_d      = y_q;
          row_base_d = y_base;
          wr_addr_d  = y_base + ADDR_W'(x_q);
          wr_en_d    = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        // While stalled, address, data and enable all hold.
        if (wr_en_q && !wr_stall) begin
          if ({1'b0, col_q} < x_end_q) begin
            col_d     = col_q + 9'd1;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end else if ({2'b0, row_q} < y_end_q) begin
            col_d      = x_q;
            row_d      = row_q + 8'd1;
            row_base_d = row_base_q + FB_WA;
            wr_addr_d  = row_base_q + FB_WA + ADDR_W'(x_q);
          end else begin
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        wr_en_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset discards any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      row_base_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      row_base_q  <= row_base_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
